// File: rtl/if_id_fetch_queue_if.sv
// Handshake and data bundle between the IF stage, the fetch queue and the ID stage.
// The queue uses the slave modport; the IF/ID environment uses master.
interface if_id_fetch_queue_if #(
    parameter int PTR_W = 1
);
    logic              IF_Valid;
    logic [31:0]       IF_Instruction;
    logic [31:0]       IF_currAddress;
    logic [31:0]       IF_PCadd4;
    logic              IF_Ready;
    logic              ID_Accept;
    logic              Flush;
    logic              ID_Valid;
    logic [31:0]       ID_Instruction;
    logic [31:0]       ID_currAddress;
    logic [31:0]       ID_PCadd4;
    logic [25:0]       ID_targetAddress;
    logic [PTR_W:0]    Count;
    logic [15:0]       FlushCount;
    logic [15:0]       StallCount;

    modport master (
        output IF_Valid, IF_Instruction, IF_currAddress, IF_PCadd4, ID_Accept, Flush,
        input  IF_Ready, ID_Valid, ID_Instruction, ID_currAddress, ID_PCadd4,
               ID_targetAddress, Count, FlushCount, StallCount
    );

    modport slave (
        input  IF_Valid, IF_Instruction, IF_currAddress, IF_PCadd4, ID_Accept, Flush,
        output IF_Ready, ID_Valid, ID_Instruction, ID_currAddress, ID_PCadd4,
               ID_targetAddress, Count, FlushCount, StallCount
    );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF->ID decoupling queue: circular buffer of {PC, PC+4, instruction} with flush.
// Define IFQ_PERF_EN to build the saturating flush/stall performance counters.
module if_id_fetch_queue #(
    parameter int          DEPTH     = 2,
    parameter int          PTR_W     = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               Clk,
    input  logic               Reset,
    if_id_fetch_queue_if.slave q
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ZERO_CNT = {(PTR_W+1){1'b0}};

    logic [95:0]      mem_q [DEPTH];
    logic [95:0]      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    logic        push_s;
    logic        pop_s;
    logic        if_ready_s;
    logic        id_valid_s;
    logic [95:0] head_s;
    logic [31:0] id_instr_s;
    logic [31:0] id_pc_s;
    logic [31:0] id_pc4_s;

    // Handshake qualifiers; ready is not pop-aware so ID_Accept never reaches IF_Ready.
    always_comb begin
        if_ready_s = (cnt_q != FULL_CNT);
        id_valid_s = (cnt_q != ZERO_CNT);
        push_s     = q.IF_Valid  & if_ready_s & ~q.Flush;
        pop_s      = q.ID_Accept & id_valid_s & ~q.Flush;
    end

    // Pointer/occupancy next state; a flush realigns rd_ptr onto wr_ptr.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (q.Flush) begin
            rd_ptr_d = wr_ptr_q;
            cnt_d    = ZERO_CNT;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
            cnt_d    = cnt_q + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {q.IF_currAddress, q.IF_PCadd4, q.IF_Instruction};
        end else begin
            mem_d = mem_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= ZERO_CNT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage is meaningless while cnt is zero, so it carries no reset.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head_s = mem_q[rd_ptr_q];
        if (id_valid_s) begin
            id_pc_s    = head_s[95:64];
            id_pc4_s   = head_s[63:32];
            id_instr_s = head_s[31:0];
        end else begin
            id_pc_s    = 32'h0000_0000;
            id_pc4_s   = 32'h0000_0000;
            id_instr_s = NOP_INSTR;
        end
    end

    assign q.IF_Ready         = if_ready_s;
    assign q.ID_Valid         = id_valid_s;
    assign q.ID_Instruction   = id_instr_s;
    assign q.ID_currAddress   = id_pc_s;
    assign q.ID_PCadd4        = id_pc4_s;
    assign q.ID_targetAddress = id_instr_s[25:0];
    assign q.Count            = cnt_q;

`ifdef IFQ_PERF_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (q.Flush && id_valid_s && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
        if (id_valid_s && !q.ID_Accept && !q.Flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flush_cnt_q <= 16'h0000;
            stall_cnt_q <= 16'h0000;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign q.FlushCount = flush_cnt_q;
    assign q.StallCount = stall_cnt_q;
`else
    assign q.FlushCount = 16'h0000;
    assign q.StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed table, reset/perf sequences,
// and randomized traffic against a queue-based reference model.
module tb_if_id_fetch_queue;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    if_id_fetch_queue_if #(.PTR_W(PTR_W)) bus ();

    if_id_fetch_queue #(
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .q    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: FIFO contents as {pc, pc+4, instr}, plus perf counts.
    logic [95:0] mq[$];
    int          m_flush;
    int          m_stall;

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        acc;
        logic        fl;
        logic [1:0]  e_cnt;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl [17];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [95:0] h;
        logic [31:0] ef;
        logic [31:0] es;
        int          n;
        n = mq.size();
        h = (n != 0) ? mq[0] : 96'h0;
`ifdef IFQ_PERF_EN
        ef = 32'(m_flush);
        es = 32'(m_stall);
`else
        ef = 32'h0;
        es = 32'h0;
`endif
        check32({tag, ".count"},  32'(bus.Count), 32'(n));
        check32({tag, ".valid"},  32'(bus.ID_Valid), (n != 0) ? 32'd1 : 32'd0);
        check32({tag, ".ready"},  32'(bus.IF_Ready), (n < DEPTH) ? 32'd1 : 32'd0);
        check32({tag, ".instr"},  bus.ID_Instruction, h[31:0]);
        check32({tag, ".pc"},     bus.ID_currAddress, h[95:64]);
        check32({tag, ".pc4"},    bus.ID_PCadd4, h[63:32]);
        check32({tag, ".target"}, 32'(bus.ID_targetAddress), {6'b0, h[25:0]});
        check32({tag, ".flushc"}, 32'(bus.FlushCount), ef);
        check32({tag, ".stallc"}, 32'(bus.StallCount), es);
    endtask

    // One clock of traffic: drive, advance the model by the queue rules, compare.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic acc, input logic fl, input string tag);
        bit ready;
        bit valid;
        bus.IF_Valid       = v;
        bus.IF_Instruction = instr;
        bus.IF_currAddress = pc;
        bus.IF_PCadd4      = pc + 32'd4;
        bus.ID_Accept      = acc;
        bus.Flush          = fl;
        ready = (mq.size() < DEPTH);
        valid = (mq.size() != 0);
        @(posedge Clk);
        #1;
        if (fl) begin
            if (valid && m_flush < 65535) m_flush++;
            mq.delete();
        end else begin
            if (valid && !acc && m_stall < 65535) m_stall++;
            if (acc && valid) void'(mq.pop_front());
            if (v && ready) mq.push_back({pc, pc + 32'd4, instr});
        end
        check_model(tag);
    endtask

    task automatic do_reset();
        bus.IF_Valid       = 1'b1;
        bus.IF_Instruction = 32'hDEAD_BEEF;
        bus.IF_currAddress = 32'h0000_0F00;
        bus.IF_PCadd4      = 32'h0000_0F04;
        bus.ID_Accept      = 1'b1;
        bus.Flush          = 1'b0;
        Reset = 1'b1;
        mq.delete();
        m_flush = 0;
        m_stall = 0;
        #2;
        check_model("rst_async");
        @(posedge Clk);
        #1;
        check_model("rst_held");
        Reset = 1'b0;
        bus.IF_Valid = 1'b0;
        bus.ID_Accept = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        bus.IF_Valid = 1'b0; bus.IF_Instruction = 32'h0; bus.IF_currAddress = 32'h0;
        bus.IF_PCadd4 = 32'h0; bus.ID_Accept = 1'b0; bus.Flush = 1'b0;

        tbl[0]  = '{1'b1, 32'h8C010004, 32'h00, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h00, 32'h8C010004};
        tbl[1]  = '{1'b1, 32'h8C020008, 32'h04, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h04, 32'h8C020008};
        tbl[2]  = '{1'b1, 32'h00221820, 32'h08, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h08, 32'h00221820};
        tbl[3]  = '{1'b0, 32'h00000000, 32'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00000000};
        tbl[4]  = '{1'b1, 32'h11110000, 32'h00, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h00, 32'h11110000};
        tbl[5]  = '{1'b1, 32'h22220004, 32'h04, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h00, 32'h11110000};
        tbl[6]  = '{1'b1, 32'h33330008, 32'h08, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h00, 32'h11110000};
        tbl[7]  = '{1'b1, 32'h33330008, 32'h08, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h04, 32'h22220004};
        tbl[8]  = '{1'b1, 32'h33330008, 32'h08, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h08, 32'h33330008};
        tbl[9]  = '{1'b1, 32'h4444000C, 32'h0C, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h0C, 32'h4444000C};
        tbl[10] = '{1'b1, 32'h55550010, 32'h10, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h0C, 32'h4444000C};
        tbl[11] = '{1'b1, 32'h66660014, 32'h14, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h10, 32'h55550010};
        tbl[12] = '{1'b1, 32'h66660014, 32'h14, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h10, 32'h55550010};
        tbl[13] = '{1'b1, 32'h77770018, 32'h18, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00000000};
        tbl[14] = '{1'b1, 32'h88880040, 32'h40, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h40, 32'h88880040};
        tbl[15] = '{1'b0, 32'h00000000, 32'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00000000};
        tbl[16] = '{1'b0, 32'h00000000, 32'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00000000};

        do_reset();

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].v, tbl[i].instr, tbl[i].pc, tbl[i].acc, tbl[i].fl, $sformatf("row%0d", i));
            check32($sformatf("tbl%0d.count", i), 32'(bus.Count), 32'(tbl[i].e_cnt));
            check32($sformatf("tbl%0d.valid", i), 32'(bus.ID_Valid), 32'(tbl[i].e_valid));
            check32($sformatf("tbl%0d.ready", i), 32'(bus.IF_Ready), 32'(tbl[i].e_ready));
            check32($sformatf("tbl%0d.pc", i), bus.ID_currAddress, tbl[i].e_pc);
            check32($sformatf("tbl%0d.pc4", i), bus.ID_PCadd4,
                    tbl[i].e_valid ? tbl[i].e_pc + 32'd4 : 32'h0);
            check32($sformatf("tbl%0d.instr", i), bus.ID_Instruction, tbl[i].e_instr);
        end

        // Reset arriving with one entry queued must empty the queue at once.
        cycle(1'b1, 32'hABCD0100, 32'h100, 1'b0, 1'b0, "prefill");
        check32("prefill_count", 32'(bus.Count), 32'd1);
        do_reset();
        check32("midrst_count", 32'(bus.Count), 32'd0);
        check32("midrst_valid", 32'(bus.ID_Valid), 32'd0);
        check32("midrst_instr", bus.ID_Instruction, 32'h0);
        check32("midrst_ready", 32'(bus.IF_Ready), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "post_rst_idle");

        // Five stall cycles, then a flush while one entry is held.
        cycle(1'b1, 32'h12340000, 32'h200, 1'b0, 1'b0, "perf_push");
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "perf_stall");
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "perf_flush");
`ifdef IFQ_PERF_EN
        check32("stall5", 32'(bus.StallCount), 32'd5);
        check32("flush1", 32'(bus.FlushCount), 32'd1);
        cycle(1'b1, 32'h12340004, 32'h204, 1'b0, 1'b0, "sat_push");
        for (int i = 0; i < 70000; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, "sat_stall");
        check32("stall_sat", 32'(bus.StallCount), 32'h0000FFFF);
        check32("flush_hold", 32'(bus.FlushCount), 32'd1);
`else
        check32("stall_off", 32'(bus.StallCount), 32'd0);
        check32("flush_off", 32'(bus.FlushCount), 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom, 32'($urandom_range(0, 16383)) << 2,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
